hamming_encoder_11_7_stream: RTL and testbench
==============================================

Name: hamming_encoder_11_7_stream

Overview:
Streaming Hamming(11,7) encoder. It sits directly upstream of the 11→7 decoder and produces the 11-bit codeword that the decoder consumes on its encoded_in input. Input and output use valid/ready handshakes, with a 2-entry output FIFO between them. An optional single-bit error-injection path corrupts selected codewords so the downstream decoder's detection and correction can be exercised in-system.

Parameters:
CNT_W, 16, width of the accepted-word counter
INJ_EN_PARAM, 1, 1 = error-injection logic present; 0 = inj_* ports ignored and all injection logic tied off

Ports:
clk  input  1  clock; all state updates on the rising edge
areset_n  input  1  asynchronous active-low reset
in_data  input  7  data word to encode
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word this cycle
inj_en  input  1  flip one codeword bit for the word accepted this cycle
inj_pos  input  4  1-based codeword position to flip (1..11)
out_code  output  11  encoded word; index = position-1
out_valid  output  1  out_code is valid
out_ready  input  1  downstream accepts out_code
word_count  output  CNT_W  number of words accepted since reset

Behaviour:
- Reset (asynchronous, areset_n=0):
  - FIFO emptied; out_valid=0, out_code=0, word_count=0, in_ready=0.
  - in_ready rises on the first clock edge after reset release.
- Codeword layout:
  - Parity bits at indices 0, 1, 3, 7.
  - Data bits: d0→2, d1→4, d2→5, d3→6, d4→8, d5→9, d6→10.
  - p1[0] = ^{[2],[4],[6],[8],[10]}
  - p2[1] = ^{[2],[5],[6],[9],[10]}
  - p4[3] = ^{[4],[5],[6]}
  - p8[7] = ^{[8],[9],[10]}
  - The decoder's syndrome is therefore 0 for an uncorrupted word.
- Accept: a word is accepted on a rising edge when in_valid & in_ready.
  - The word is encoded combinationally and pushed into the FIFO in the same edge.
  - word_count increments by 1 and wraps at 2^CNT_W-1 → 0.
- Injection: evaluated only on an accept edge.
  - If inj_en=1 and inj_pos is 1..11, bit index inj_pos-1 of the pushed word is inverted.
  - inj_pos = 0 or 12..15: no flip, word pushed clean.
  - inj_en is ignored on cycles with no accept.
- Latency: accept into an empty FIFO → out_valid=1 with that word on the next cycle (1 cycle).
- FIFO: 2 entries, rd_ptr/wr_ptr plus a 2-bit occupancy count.
  - in_ready = (count != 2). It is registered-state-derived and has no combinational path from out_ready.
  - out_valid = (count != 0); out_code = head entry, driven from register.
  - Pop on out_valid & out_ready.
  - Push and pop on the same edge: count unchanged, head advances, new word written at tail.
  - Full (count=2): in_ready=0. A pop on that edge does not admit a push in the same cycle; a push is possible on the next cycle.
  - Empty with push only: count→1.
- Output stability: while out_valid=1 and out_ready=0, out_code must not change.
- Reset mid-operation: all buffered words are discarded and the counter clears. No partial word is emitted after release.
- INJ_EN_PARAM=0: inj_en and inj_pos have no effect.

Decomposition:
- Shared package hamming_11_7_pkg:
  - localparams for parity indices (0, 1, 3, 7) and the data-bit index table.
  - CODE_W=11, DATA_W=7.
  - function hamming_encode_11_7(data[6:0]) → [10:0].
  - Intended for reuse by the decoder and by the benches.
- One sub-module: hamming_enc_11_7_core, purely combinational (data + inj_en/inj_pos → code). The FIFO and counter remain in the top module.

Test Plan:
- Encode vectors: push 7'h01 → 11'h007; 7'h40 → 11'h483; 7'h7F → 11'h7FF; 7'h00 → 11'h000. Each is out_valid one cycle after accept with out_ready=1.
- Exhaustive loopback: all 128 inputs through this block into the decoder with no injection → data_out equals input, error_flag=0 every word, word_count=128.
- Injection: push 7'h00 with inj_en=1, inj_pos=5 → out_code=11'h010, decoder flags and corrects to 7'h00. With inj_pos=0 or 13 → 11'h000.
- Backpressure: hold out_ready=0 and push 3 words (7'h01, 7'h02, 7'h03).
  - in_ready drops after the 2nd word; out_code holds 11'h007 stable.
  - After releasing out_ready: outputs are in order 11'h007, then the encodes of 7'h02 and 7'h03; no loss and no duplicates.
- Simultaneous push/pop at count=1 with continuous in_valid and out_ready=1 → count stays 1 and throughput is 1 word/cycle.
- Async reset with 2 words buffered → out_valid=0 and word_count=0 immediately (before the next edge); after release the first output is the first word pushed post-reset.

Source files
------------

// File: rtl/hamming_11_7_pkg.sv
// Shared Hamming(11,7) definitions: codeword geometry and the reference encoder.
// Reused by the encoder, the downstream decoder and verification benches.
package hamming_11_7_pkg;

    localparam int unsigned CODE_W    = 11;
    localparam int unsigned DATA_W    = 7;
    localparam int unsigned INJ_POS_W = 4;

    // Parity bit indices (position-1 of positions 1, 2, 4, 8)
    localparam int unsigned P1_IDX = 0;
    localparam int unsigned P2_IDX = 1;
    localparam int unsigned P4_IDX = 3;
    localparam int unsigned P8_IDX = 7;

    // Codeword index of data bit d0..d6
    localparam int unsigned DATA_IDX [DATA_W] = '{2, 4, 5, 6, 8, 9, 10};

    // Place data bits, then compute even parity over each covered group
    function automatic logic [CODE_W-1:0] hamming_encode_11_7(input logic [DATA_W-1:0] data);
        logic [CODE_W-1:0] c;
        c = '0;
        c[4'(DATA_IDX[0])] = data[0];
        c[4'(DATA_IDX[1])] = data[1];
        c[4'(DATA_IDX[2])] = data[2];
        c[4'(DATA_IDX[3])] = data[3];
        c[4'(DATA_IDX[4])] = data[4];
        c[4'(DATA_IDX[5])] = data[5];
        c[4'(DATA_IDX[6])] = data[6];
        c[4'(P1_IDX)] = ^{c[2], c[4], c[6], c[8], c[10]};
        c[4'(P2_IDX)] = ^{c[2], c[5], c[6], c[9], c[10]};
        c[4'(P4_IDX)] = ^{c[4], c[5], c[6]};
        c[4'(P8_IDX)] = ^{c[8], c[9], c[10]};
        return c;
    endfunction

endpackage

// File: rtl/hamming_encoder_11_7_stream_if.sv
// Stream bundle for the Hamming(11,7) encoder: input word + injection control,
// output codeword, valid/ready on both sides.
//   master: traffic source / sink (environment)
//   slave : the encoder block
interface hamming_encoder_11_7_stream_if;
    import hamming_11_7_pkg::*;

    logic [DATA_W-1:0]    in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 inj_en;
    logic [INJ_POS_W-1:0] inj_pos;
    logic [CODE_W-1:0]    out_code;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output in_data, in_valid, inj_en, inj_pos, out_ready,
        input  in_ready, out_code, out_valid
    );

    modport slave (
        input  in_data, in_valid, inj_en, inj_pos, out_ready,
        output in_ready, out_code, out_valid
    );

endinterface

// File: rtl/hamming_enc_11_7_core.sv
// Combinational Hamming(11,7) encode with optional single-bit error injection.
// Ports: data (7b) in, inj_en/inj_pos in, code_c (11b) out.
module hamming_enc_11_7_core
    import hamming_11_7_pkg::*;
#(
    parameter int unsigned INJ_EN_PARAM = 1
) (
    input  logic [DATA_W-1:0]    data,
    input  logic                 inj_en,
    input  logic [INJ_POS_W-1:0] inj_pos,
    output logic [CODE_W-1:0]    code_c
);

    logic [CODE_W-1:0] flip_mask;

    // Positions outside 1..11 leave the word clean
    always_comb begin
        flip_mask = '0;
        if ((INJ_EN_PARAM != 0) && inj_en &&
            (inj_pos >= 4'd1) && (inj_pos <= 4'(CODE_W))) begin
            flip_mask = CODE_W'(1) << (inj_pos - 4'd1);
        end
        code_c = hamming_encode_11_7(data) ^ flip_mask;
    end

endmodule

// File: rtl/hamming_encoder_11_7_stream.sv
// Streaming Hamming(11,7) encoder with 2-entry output FIFO and accepted-word counter.
// Ports: clk, areset_n (async active-low), bus (slave modport: in_* / inj_* / out_*),
//        word_count (words accepted since reset, wraps).
module hamming_encoder_11_7_stream
    import hamming_11_7_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned INJ_EN_PARAM = 1
) (
    input  logic                          clk,
    input  logic                          areset_n,
    hamming_encoder_11_7_stream_if.slave  bus,
    output logic [CNT_W-1:0]              word_count
);

    localparam int unsigned DEPTH = 2;

    logic [CODE_W-1:0] code_c;
    logic              accept_c;
    logic              pop_c;

    logic [CODE_W-1:0] mem_q [DEPTH];
    logic [CODE_W-1:0] mem_d [DEPTH];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [CODE_W-1:0] out_code_q, out_code_d;
    logic [CNT_W-1:0]  word_count_q, word_count_d;

    hamming_enc_11_7_core #(
        .INJ_EN_PARAM (INJ_EN_PARAM)
    ) u_core (
        .data    (bus.in_data),
        .inj_en  (bus.inj_en),
        .inj_pos (bus.inj_pos),
        .code_c  (code_c)
    );

    // Handshakes are qualified only by registered flags, so no out_ready -> in_ready path
    assign accept_c = bus.in_valid & in_ready_q;
    assign pop_c    = out_valid_q & bus.out_ready;

    // FIFO / counter next state; flags and head word precomputed for registered outputs
    always_comb begin
        mem_d        = mem_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        word_count_d = word_count_q;

        if (accept_c) begin
            mem_d[wr_ptr_q] = code_c;
            wr_ptr_d        = ~wr_ptr_q;
            word_count_d    = word_count_q + CNT_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        unique case ({accept_c, pop_c})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        in_ready_d  = (count_d != 2'(DEPTH));
        out_valid_d = (count_d != 2'd0);
        out_code_d  = out_valid_d ? mem_d[rd_ptr_d] : '0;
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            mem_q[0]     <= '0;
            mem_q[1]     <= '0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_code_q   <= '0;
            word_count_q <= '0;
        end else begin
            mem_q        <= mem_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_code_q   <= out_code_d;
            word_count_q <= word_count_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_code  = out_code_q;
    assign word_count    = word_count_q;

endmodule

// File: tb/tb_hamming_encoder_11_7_stream.sv
// Self-checking bench for hamming_encoder_11_7_stream: scoreboard of expected
// codewords plus a positional-syndrome decoder model on every output word.
module tb_hamming_encoder_11_7_stream;

    typedef struct {
        logic [10:0] code;
        logic [6:0]  data;
        logic [3:0]  syn;
    } exp_t;

    logic        clk;
    logic        areset_n;
    logic [15:0] word_count;

    int n_vec;
    int n_err;
    exp_t exp_q[$];

    hamming_encoder_11_7_stream_if bus();

    hamming_encoder_11_7_stream #(
        .CNT_W        (16),
        .INJ_EN_PARAM (1)
    ) dut (
        .clk        (clk),
        .areset_n   (areset_n),
        .bus        (bus),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder by position: parity at 2^k covers every position with bit k set
    function automatic logic [10:0] bm_encode(input logic [6:0] d);
        logic [10:0] c;
        int dpos [7];
        dpos = '{3, 5, 6, 7, 9, 10, 11};
        c = '0;
        for (int i = 0; i < 7; i++) c[dpos[i]-1] = d[i];
        for (int k = 0; k < 4; k++) begin
            logic p;
            p = 1'b0;
            for (int pos = 1; pos <= 11; pos++)
                if (((pos >> k) & 1) == 1 && pos != (1 << k)) p = p ^ c[pos-1];
            c[(1 << k)-1] = p;
        end
        return c;
    endfunction

    function automatic logic [3:0] bm_syndrome(input logic [10:0] c);
        logic [3:0] s;
        s = 4'd0;
        for (int pos = 1; pos <= 11; pos++) if (c[pos-1]) s = s ^ 4'(pos);
        return s;
    endfunction

    function automatic logic [6:0] bm_decode(input logic [10:0] c);
        logic [10:0] f;
        logic [3:0]  s;
        int dpos [7];
        logic [6:0]  d;
        dpos = '{3, 5, 6, 7, 9, 10, 11};
        f = c;
        s = bm_syndrome(c);
        if (s >= 4'd1 && s <= 4'd11) f[s-1] = ~f[s-1];
        for (int i = 0; i < 7; i++) d[i] = f[dpos[i]-1];
        return d;
    endfunction

    // Scoreboard: capture accepts, check pops (both handshakes decided by values stable at negedge)
    always @(negedge clk) begin
        if (!areset_n) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: got code %h, required no output", bus.out_code);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (bus.out_code !== e.code) begin
                        n_err++;
                        $display("FAIL sb_code: got %h required %h", bus.out_code, e.code);
                    end
                    n_vec++;
                    if (bm_syndrome(bus.out_code) !== e.syn || bm_decode(bus.out_code) !== e.data) begin
                        n_err++;
                        $display("FAIL sb_decode: got syn %0d data %h required syn %0d data %h",
                                 bm_syndrome(bus.out_code), bm_decode(bus.out_code), e.syn, e.data);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_t e;
                logic act;
                act    = bus.inj_en && bus.inj_pos >= 4'd1 && bus.inj_pos <= 4'd11;
                e.data = bus.in_data;
                e.code = bm_encode(bus.in_data);
                e.syn  = act ? bus.inj_pos : 4'd0;
                if (act) e.code[bus.inj_pos-1] = ~e.code[bus.inj_pos-1];
                exp_q.push_back(e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        areset_n = 1'b0;
        #2;
        @(posedge clk); #1;
        areset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Present one word and hold it until accepted (bounded)
    task automatic push_one(input logic [6:0] d, input logic ie, input logic [3:0] ip);
        bit done;
        done = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.inj_en   = ie;
        bus.inj_pos  = ip;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk); #1;
                done = 1;
            end
        end
        bus.in_valid = 1'b0;
        bus.inj_en   = 1'b0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL push_timeout: word %h not accepted within 20 cycles", d);
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, out_valid %b, required 0 pending, out_valid 0",
                     exp_q.size(), bus.out_valid);
        end
    endtask

    task automatic test_reset();
        areset_n = 1'b0;
        #2;
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_code !== 11'h000 || word_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_state: got v=%b r=%b code=%h cnt=%0d required 0 0 000 0",
                     bus.out_valid, bus.in_ready, bus.out_code, word_count);
        end
        @(posedge clk); #1;
        areset_n = 1'b1;
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ready_before_edge: got %b required 0", bus.in_ready);
        end
        @(posedge clk); #1;
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_edge: got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_encode_vectors();
        logic [6:0]  din [4];
        logic [10:0] want [4];
        din  = '{7'h01, 7'h40, 7'h7F, 7'h00};
        want = '{11'h007, 11'h483, 11'h7FF, 11'h000};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_one(din[i], 1'b0, 4'd0);
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.out_code !== want[i]) begin
                n_err++;
                $display("FAIL encode_%0d: got v=%b code=%h required v=1 code=%h",
                         i, bus.out_valid, bus.out_code, want[i]);
            end
        end
        drain();
    endtask

    task automatic test_injection();
        logic [3:0]  pos [4];
        logic [10:0] want [4];
        pos  = '{4'd5, 4'd0, 4'd13, 4'd11};
        want = '{11'h010, 11'h000, 11'h000, 11'h400};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_one(7'h00, 1'b1, pos[i]);
            n_vec++;
            if (bus.out_code !== want[i]) begin
                n_err++;
                $display("FAIL inject_pos%0d: got %h required %h", pos[i], bus.out_code, want[i]);
            end
        end
        // inj_en with no accept must not affect a later clean word
        bus.inj_en = 1'b1; bus.inj_pos = 4'd3;
        @(posedge clk); #1;
        push_one(7'h00, 1'b0, 4'd3);
        n_vec++;
        if (bus.out_code !== 11'h000) begin
            n_err++;
            $display("FAIL inject_idle: got %h required 000", bus.out_code);
        end
        drain();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        push_one(7'h01, 1'b0, 4'd0);
        push_one(7'h02, 1'b0, 4'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 7'h03;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_code !== 11'h007) begin
                n_err++;
                $display("FAIL bp_hold_%0d: got r=%b v=%b code=%h required 0 1 007",
                         i, bus.in_ready, bus.out_valid, bus.out_code);
            end
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_full_pop: got in_ready %b required 0", bus.in_ready);
        end
        @(posedge clk); #1;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_code !== 11'h019) begin
            n_err++;
            $display("FAIL bp_after_pop: got r=%b code=%h required 1 019", bus.in_ready, bus.out_code);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_vec++;
        if (bus.out_code !== 11'h01E) begin
            n_err++;
            $display("FAIL bp_third: got %h required 01E", bus.out_code);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        bus.out_ready = 1'b1;
        bus.inj_en    = 1'b0;
        for (int i = 0; i < 128; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 7'(i);
            @(negedge clk);
            n_vec++;
            if (bus.in_ready !== 1'b1 || (i > 0 && bus.out_valid !== 1'b1)) begin
                n_err++;
                $display("FAIL b2b_rate_%0d: got r=%b v=%b required 1 1", i, bus.in_ready, bus.out_valid);
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        n_vec++;
        if (word_count !== 16'd128) begin
            n_err++;
            $display("FAIL word_count: got %0d required 128", word_count);
        end
        drain();
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        push_one(7'h11, 1'b0, 4'd0);
        push_one(7'h22, 1'b0, 4'd0);
        #2;
        areset_n = 1'b0;
        #1;
        n_vec++;
        if (bus.out_valid !== 1'b0 || word_count !== 16'd0 || bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got v=%b cnt=%0d r=%b required 0 0 0",
                     bus.out_valid, word_count, bus.in_ready);
        end
        @(posedge clk); #1;
        areset_n = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        push_one(7'h55, 1'b0, 4'd0);
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_code !== bm_encode(7'h55) || word_count !== 16'd1) begin
            n_err++;
            $display("FAIL post_reset_first: got v=%b code=%h cnt=%0d required 1 %h 1",
                     bus.out_valid, bus.out_code, word_count, bm_encode(7'h55));
        end
        drain();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        areset_n      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.inj_en    = 1'b0;
        bus.inj_pos   = '0;
        bus.out_ready = 1'b0;

        test_reset();
        test_encode_vectors();
        test_injection();
        test_backpressure();
        test_back_to_back();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
